// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues sequential reads under a buffer-credit limit,
// queues returned words with their PCs, and flushes/drops stale data on redirect.
module ifetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] resp_pc, resp_pc_n;
    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc    [DEPTH];
    ptr_t        rd_ptr, rd_ptr_n;
    ptr_t        wr_ptr, wr_ptr_n;
    cnt_t        count, count_n;
    cnt_t        outstanding, outstanding_n;
    cnt_t        discard, discard_n;

    logic [CW:0] credit_used;
    logic        grant;
    logic        rsp;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;
    logic        unused_addr_bits;

    assign redirect_pc      = {redirect_addr[31:2], 2'b00};
    assign unused_addr_bits = ^redirect_addr[1:0];

    // Outstanding requests reserve buffer slots, so a response can always be pushed.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign mem_req     = ~reset & ~redirect & (credit_used < DEPTH_C);
    assign mem_addr    = fetch_pc;
    assign grant       = mem_req & mem_gnt;

    // A response with nothing outstanding is spurious and leaves state untouched.
    assign rsp  = mem_rvalid & (outstanding != '0) & ~reset;
    assign push = rsp & ~redirect & (discard == '0);

    assign instr_valid = (count != '0) & ~redirect;
    assign pop         = instr_valid & instr_ready;
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    always_comb begin
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;
        count_n       = count;
        outstanding_n = outstanding;
        discard_n     = discard;
        if (redirect) begin
            // Everything still in flight becomes stale; a response arriving now is already dropped.
            fetch_pc_n    = redirect_pc;
            resp_pc_n     = redirect_pc;
            rd_ptr_n      = '0;
            wr_ptr_n      = '0;
            count_n       = '0;
            outstanding_n = outstanding - cnt_t'(rsp);
            discard_n     = outstanding - cnt_t'(rsp);
        end else begin
            if (grant) begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
            outstanding_n = outstanding + cnt_t'(grant) - cnt_t'(rsp);
            if (rsp && (discard != '0)) begin
                discard_n = discard - cnt_t'(1);
            end
            if (push) begin
                resp_pc_n = resp_pc + 32'd4;
                wr_ptr_n  = wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + ptr_t'(1);
            end
            count_n = count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
        end
    end

    // Storage needs no reset; count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= mem_rdata;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order memory that answers one cycle after grant.
module tb_ifetch_unit;
    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int tests = 0;
    int fails = 0;
    int grants = 0;
    bit auto_rsp = 1'b1;
    logic [31:0] pend [$];

    ifetch_unit #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        if (auto_rsp && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat(pend[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    // One clock: memory model notes grant/response taken at the edge, then drives next response.
    task automatic tick();
        logic g, rv, rs;
        logic [31:0] a, dummy;
        g  = mem_req & mem_gnt;
        a  = mem_addr;
        rv = mem_rvalid;
        rs = reset;
        @(posedge clk);
        #1;
        if (rs) begin
            pend.delete();
        end else begin
            if (rv && pend.size() > 0) dummy = pend.pop_front();
            if (g) begin
                pend.push_back(a);
                grants++;
            end
        end
        drive_rsp();
        #1;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_addr = 32'h0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b1;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_valid", instr_valid, 0);
        tick(); tick();
        check("rst_req2", mem_req, 0);

        // Streaming after reset release
        reset = 1'b0; #1;
        check("a_c0_req", mem_req, 1);
        check("a_c0_addr", mem_addr, 32'h0);
        tick();
        check("a_c1_addr", mem_addr, 32'h4);
        check("a_c1_valid", instr_valid, 0);
        tick();
        check("a_c2_valid", instr_valid, 1);
        check("a_c2_pc", instr_pc, 32'h0);
        check("a_c2_instr", instr, dat(32'h0));
        check("a_c2_addr", mem_addr, 32'h8);
        tick();
        check("a_c3_pc", instr_pc, 32'h4);
        check("a_c3_instr", instr, dat(32'h4));
        check("a_c3_addr", mem_addr, 32'hC);
        tick();
        check("a_c4_valid", instr_valid, 1);
        check("a_c4_pc", instr_pc, 32'h8);

        // Back-pressure fills the buffer, then drains in order
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0; grants = 0; #1;
        tick(); tick(); tick(); tick(); tick();
        check("b_grants", grants, 4);
        check("b_req_full", mem_req, 0);
        check("b_pc0", instr_pc, 32'h0);
        tick();
        check("b_req_hold", mem_req, 0);
        check("b_grants2", grants, 4);
        instr_ready = 1'b1; #1;
        check("b_d0_pc", instr_pc, 32'h0);
        check("b_d0_req", mem_req, 0);
        check("b_d0_addr", mem_addr, 32'h10);
        tick();
        check("b_d1_pc", instr_pc, 32'h4);
        check("b_d1_req", mem_req, 1);
        check("b_d1_addr", mem_addr, 32'h10);
        tick();
        check("b_d2_pc", instr_pc, 32'h8);
        tick();
        check("b_d3_pc", instr_pc, 32'hC);
        check("b_d3_instr", instr, dat(32'hC));
        tick();
        check("b_d4_pc", instr_pc, 32'h10);
        check("b_d4_instr", instr, dat(32'h10));

        // Redirect with two responses (8, C) outstanding
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        tick(); tick();
        auto_rsp = 1'b0;
        tick(); tick();
        check("c_pre_addr", mem_addr, 32'h10);
        check("c_pre_valid", instr_valid, 0);
        redirect = 1'b1; redirect_addr = 32'h0000_0103; #1;
        check("c_redir_req", mem_req, 0);
        tick();
        redirect = 1'b0; auto_rsp = 1'b1; drive_rsp(); #1;
        check("c_r1_addr", mem_addr, 32'h100);
        check("c_r1_req", mem_req, 1);
        check("c_r1_valid", instr_valid, 0);
        tick();
        check("c_r2_valid", instr_valid, 0);
        tick();
        check("c_r3_valid", instr_valid, 0);
        tick();
        check("c_r4_valid", instr_valid, 1);
        check("c_r4_pc", instr_pc, 32'h100);
        check("c_r4_instr", instr, dat(32'h100));
        tick();

        // Redirect coinciding with a response and a ready decode stage
        redirect = 1'b1; redirect_addr = 32'h0000_0200; #1;
        check("d_rvalid_pre", mem_rvalid, 1);
        check("d_valid_redir", instr_valid, 0);
        check("d_req_redir", mem_req, 0);
        tick();
        redirect = 1'b0; #1;
        check("d_r6_valid", instr_valid, 0);
        check("d_r6_addr", mem_addr, 32'h200);
        check("d_r6_req", mem_req, 1);
        tick();
        check("d_r7_valid", instr_valid, 0);
        tick();
        check("d_r8_valid", instr_valid, 1);
        check("d_r8_pc", instr_pc, 32'h200);
        check("d_r8_instr", instr, dat(32'h200));

        // Address wrap at the top of the space
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; #1;
        tick();
        redirect = 1'b0; #1;
        check("e_w1_addr", mem_addr, 32'hFFFF_FFFC);
        check("e_w1_req", mem_req, 1);
        check("e_w1_valid", instr_valid, 0);
        tick();
        check("e_w2_addr", mem_addr, 32'h0);
        tick();
        check("e_w3_pc", instr_pc, 32'hFFFF_FFFC);
        check("e_w3_instr", instr, dat(32'hFFFF_FFFC));
        check("e_w3_addr", mem_addr, 32'h4);
        tick();
        check("e_w4_pc", instr_pc, 32'h0);
        check("e_w4_instr", instr, dat(32'h0));

        // Reset with 3 buffered and 1 outstanding, overriding a redirect
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0; #1;
        tick(); tick(); tick(); tick();
        check("f_pre_pc", instr_pc, 32'h0);
        check("f_pre_req", mem_req, 0);
        reset = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0500; instr_ready = 1'b1; #1;
        check("f_rst_req", mem_req, 0);
        check("f_rst_valid", instr_valid, 0);
        tick();
        reset = 1'b0; redirect = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        check("f_post_valid", instr_valid, 0);
        check("f_post_req", mem_req, 1);
        check("f_post_addr", mem_addr, 32'h0);
        tick();
        check("f_spur_valid", instr_valid, 0);
        check("f_hold_addr", mem_addr, 32'h0);
        check("f_hold_req", mem_req, 1);
        mem_gnt = 1'b1; #1;
        tick();
        check("f_g_addr", mem_addr, 32'h4);
        tick();
        check("f_pc0", instr_pc, 32'h0);
        check("f_instr0", instr, dat(32'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  RESET_ADDR, 32'h0000_0000, first fetch address after reset
  DEPTH, 4, instruction buffer entries; power of two, >= 2
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, all state on rising edge
  reset  input  1  synchronous, active-high reset
  redirect  input  1  load new fetch address (branch/jump)
  redirect_addr  input  32  new fetch address
  mem_req  output  1  instruction memory read request
  mem_addr  output  32  request address
  mem_gnt  input  1  memory accepts request this cycle
  mem_rvalid  input  1  read data valid
  mem_rdata  input  32  read data
  instr_valid  output  1  buffered instruction available
  instr_ready  input  1  decode stage accepts instruction
  instr  output  32  instruction word
  instr_pc  output  32  address of instr
REQ-003 The clock SHALL be clk; the reset SHALL be reset, synchronous and active-high.

Function
REQ-004 Internal state: fetch_pc (32b), resp_pc (32b), buffer of DEPTH {instr, pc} entries with count, outstanding (requests granted, not yet answered), discard (stale responses to drop).
REQ-005 mem_req SHALL be 1 iff not reset, redirect=0, and outstanding + count < DEPTH; mem_addr SHALL equal fetch_pc.
REQ-006 Grant = mem_req & mem_gnt; on grant fetch_pc += 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000) and outstanding += 1.
REQ-007 While mem_req=1 and ungranted, mem_addr SHALL hold its value unless redirect or reset occurs.
REQ-008 Memory returns exactly one mem_rvalid per grant, in order, earliest the cycle after grant; grant and rvalid in one cycle SHALL update outstanding by net 0.
REQ-009 On mem_rvalid with discard>0: data dropped, discard -= 1, outstanding -= 1.
REQ-010 On mem_rvalid with discard=0: {mem_rdata, resp_pc} pushed to buffer, resp_pc += 4, outstanding -= 1.
REQ-011 mem_rvalid with outstanding=0 SHALL be ignored, no state change.
REQ-012 instr_valid SHALL equal (count != 0) & ~redirect; instr/instr_pc SHALL show the oldest entry.
REQ-013 Pop = instr_valid & instr_ready; simultaneous push and pop SHALL leave count unchanged, ordering preserved; credit rule REQ-005 guarantees push never finds buffer full.
REQ-014 Redirect cycle: buffer flushed (count <= 0); fetch_pc and resp_pc <= {redirect_addr[31:2], 2'b00}; any mem_rvalid that cycle dropped; outstanding and discard both <= outstanding - mem_rvalid; no request issued.
REQ-015 Back-to-back redirects: last one wins; discard accumulates per REQ-014.
REQ-016 Throughput: with mem_gnt=1, one-cycle response, instr_ready=1, one instruction per cycle steady-state.
REQ-017 Fetch-to-instr latency: instr_valid rises the cycle after the push edge.

Reset
REQ-018 With reset=1 at a rising edge: fetch_pc=resp_pc=RESET_ADDR, count=outstanding=discard=0; mem_req=0, instr_valid=0 while reset high.
REQ-019 Reset SHALL override redirect, grant, rvalid and pop in the same cycle; in-flight memory responses are not tracked and the memory side is reset concurrently.
REQ-020 First mem_req=1 with mem_addr=RESET_ADDR SHALL occur the first cycle reset=0.

Verification
REQ-021 Reset release, mem_gnt=1, 1-cycle response, instr_ready=1 -> mem_addr 0,4,8,...; instr_pc 0,4,8 on consecutive cycles, instr = mem_rdata order.
REQ-022 instr_ready=0, DEPTH=4 -> exactly 4 grants, then mem_req=0; count=4; raising instr_ready drains 0,4,8,C then fetch resumes at 0x10.
REQ-023 Two outstanding (addr 8, C), redirect to 0x103 -> both responses dropped, next mem_addr=0x100, first instr_pc=0x100.
REQ-024 redirect with simultaneous mem_rvalid and instr_ready -> rvalid data dropped, instr_valid=0 that cycle, count=0 next cycle.
REQ-025 Redirect to FFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000; instr_pc follows with wrap.
REQ-026 reset asserted with 3 entries buffered and 1 outstanding -> next cycle count=0, instr_valid=0, mem_req=0; after release mem_addr=RESET_ADDR.
